// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader.
// Contents: operand width, FSM state encodings (also driven onto the LEDs),
// and the add/subtract select encodings expected by the adder.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    // Encodings are visible on led_state, so they are fixed explicitly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_X    = 2'b01,
        ST_XY   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/alu_operand_loader_debounce.sv
// button_debounce: synchronises one asynchronous, bouncy push button and
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES clocks.
// Ports:
//   clk     in   board clock
//   rst_n   in   synchronous active-low reset
//   btn_in  in   raw button (asynchronous)
//   level   out  debounced button level
//   press   out  1-cycle pulse on a debounced rising edge (release gives none)
module button_debounce
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter measures how long the synchronised input has disagreed with
    // the accepted level; any agreement restarts the measurement.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: board-side front end for the ripple adder/subtractor.
// Operands are entered on the slide switches and captured by debounced push
// buttons; the loader holds them stable on the adder inputs and flags issue.
// Ports:
//   clk        in   board clock
//   rst_n      in   synchronous active-low reset
//   sw         in   operand switches
//   sw_sel     in   0=add, 1=subtract
//   btn_x      in   load X
//   btn_y      in   load Y
//   btn_go     in   latch sel and issue
//   btn_clr    in   clear all
//   x, y       out  operands to the adder
//   sel        out  add/subtract select to the adder
//   out_valid  out  1-cycle pulse on issue
//   res_valid  out  high while in DONE
//   go_err     out  1-cycle pulse when go is rejected
//   led_state  out  current state encoding
//
// state     | meaning
// ----------+------------------------------------------
// ST_IDLE   | nothing loaded
// ST_X      | X loaded, waiting for Y
// ST_XY     | X and Y loaded, waiting for go
// ST_DONE   | issued; adder result is valid
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH           = ALU_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             sw_sel,
    input  logic             btn_x,
    input  logic             btn_y,
    input  logic             btn_go,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             sel,
    output logic             out_valid,
    output logic             res_valid,
    output logic             go_err,
    output logic [1:0]       led_state
);

    logic       press_x, press_y, press_go, press_clr;
    logic [3:0] btn_level_unused;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_x (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_x),
        .level(btn_level_unused[0]), .press(press_x)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_y (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_y),
        .level(btn_level_unused[1]), .press(press_y)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_go (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_go),
        .level(btn_level_unused[2]), .press(press_go)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_clr),
        .level(btn_level_unused[3]), .press(press_clr)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic             go_err_q, go_err_d;
    logic             res_valid_q;

    // Priority clr > go > loads; a go press swallows any coincident load.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sel_d       = sel_q;
        out_valid_d = 1'b0;
        go_err_d    = 1'b0;
        if (press_clr) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            sel_d   = SEL_ADD;
        end else if (press_go) begin
            if (state_q == ST_XY) begin
                sel_d       = sw_sel;
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
            end else begin
                go_err_d = 1'b1;
            end
        end else if (press_x && press_y) begin
            x_d     = sw;
            y_d     = sw;
            state_d = ST_XY;
        end else if (press_x) begin
            x_d = sw;
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
                state_d = ST_X;
            end
        end else if (press_y) begin
            if (state_q == ST_X || state_q == ST_XY) begin
                y_d     = sw;
                state_d = ST_XY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sel_q       <= SEL_ADD;
            out_valid_q <= 1'b0;
            go_err_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            go_err_q    <= go_err_d;
            // Registered from the next state so it tracks state_q exactly.
            res_valid_q <= (state_d == ST_DONE);
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign go_err    = go_err_q;
    assign res_valid = res_valid_q;
    assign led_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

    logic       clk;
    logic       rst_n;
    logic [5:0] sw;
    logic       sw_sel;
    logic       btn_x, btn_y, btn_go, btn_clr;
    logic [5:0] x, y;
    logic       sel, out_valid, res_valid, go_err;
    logic [1:0] led_state;

    alu_operand_loader #(.WIDTH(6), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sw_sel(sw_sel),
        .btn_x(btn_x), .btn_y(btn_y), .btn_go(btn_go), .btn_clr(btn_clr),
        .x(x), .y(y), .sel(sel), .out_valid(out_valid), .res_valid(res_valid),
        .go_err(go_err), .led_state(led_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 = out_valid pulse, 1 = go_err pulse
    typedef struct {
        logic       kind;
        int         cyc;
        logic [5:0] ex;
        logic [5:0] ey;
        logic       esel;
    } ev_t;
    ev_t sb[$];
    ev_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (out_valid === 1'b1 || go_err === 1'b1) begin
            chk("pulse_exclusive", {31'b0, out_valid & go_err}, 32'd0);
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse observed=ov%0b/ge%0b@%0d expected=none",
                       out_valid, go_err, cyc);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("ev_kind", {31'b0, go_err}, {31'b0, mon_e.kind});
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_x", {26'b0, x}, {26'b0, mon_e.ex});
                chk("ev_y", {26'b0, y}, {26'b0, mon_e.ey});
                chk("ev_sel", {31'b0, sel}, {31'b0, mon_e.esel});
            end
        end
    end

    // Press for 10 cycles, release for 10. Pulse expected D+3+1 = 8 negedges
    // after the drive point (sync stage 1 samples at the next edge).
    task automatic do_press(input logic bx, input logic by, input logic bgo, input logic bclr,
                            input logic has_ev, input logic kind,
                            input logic [5:0] ex, input logic [5:0] ey, input logic esel);
        @(negedge clk);
        btn_x = bx; btn_y = by; btn_go = bgo; btn_clr = bclr;
        if (has_ev) sb.push_back('{kind, cyc + 8, ex, ey, esel});
        repeat (10) @(negedge clk);
        btn_x = 0; btn_y = 0; btn_go = 0; btn_clr = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] st, input logic [5:0] ex,
                             input logic [5:0] ey, input logic esel, input logic erv);
        chk({tag, "_led"}, {30'b0, led_state}, {30'b0, st});
        chk({tag, "_x"}, {26'b0, x}, {26'b0, ex});
        chk({tag, "_y"}, {26'b0, y}, {26'b0, ey});
        chk({tag, "_sel"}, {31'b0, sel}, {31'b0, esel});
        chk({tag, "_rv"}, {31'b0, res_valid}, {31'b0, erv});
    endtask

    initial begin
        rst_n = 0; sw = 6'b111111; sw_sel = 1;
        btn_x = 1; btn_y = 1; btn_go = 1; btn_clr = 1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {16'b0, x, y, sel, out_valid, go_err, res_valid, led_state}, 32'd0);
        rst_n = 1;
        // All buttons pressed together after reset: clr wins, nothing loads.
        repeat (10) @(negedge clk);
        chk_state("rst_allbtn", 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        btn_x = 0; btn_y = 0; btn_go = 0; btn_clr = 0;
        repeat (12) @(negedge clk);

        // Normal add sequence
        sw = 6'b110011; sw_sel = 0;
        do_press(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("load_x", 2'b01, 6'b110011, 6'd0, 1'b0, 1'b0);
        sw = 6'b001111;
        do_press(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_state("load_y", 2'b10, 6'b110011, 6'b001111, 1'b0, 1'b0);
        do_press(0, 0, 1, 0, 1, 0, 6'b110011, 6'b001111, 1'b0);
        chk_state("go_add", 2'b11, 6'b110011, 6'b001111, 1'b0, 1'b1);

        // Subtract sequence starting from DONE
        sw = 6'b000001;
        do_press(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_state("done_x", 2'b01, 6'b000001, 6'b001111, 1'b0, 1'b0);
        sw = 6'b000010; sw_sel = 1;
        do_press(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_press(0, 0, 1, 0, 1, 0, 6'b000001, 6'b000010, 1'b1);
        chk_state("go_sub", 2'b11, 6'b000001, 6'b000010, 1'b1, 1'b1);

        // go in DONE is rejected
        sw_sel = 0;
        do_press(0, 0, 1, 0, 1, 1, 6'b000001, 6'b000010, 1'b1);
        chk_state("go_in_done", 2'b11, 6'b000001, 6'b000010, 1'b1, 1'b1);

        // clr in DONE
        do_press(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk_state("clr_done", 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);

        // y in IDLE is ignored
        sw = 6'b010101;
        do_press(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_state("y_idle", 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);

        // Bounce shorter than D never registers
        sw = 6'b111000;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            btn_x = 1; repeat (2) @(negedge clk);
            btn_x = 0; repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk_state("bounce", 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);

        // go in X_LOADED
        sw = 6'b000101;
        do_press(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_press(0, 0, 1, 0, 1, 1, 6'b000101, 6'd0, 1'b0);
        chk_state("go_in_x", 2'b01, 6'b000101, 6'd0, 1'b0, 1'b0);

        // go together with x: load dropped, go rejected
        sw = 6'b111111;
        do_press(1, 0, 1, 0, 1, 1, 6'b000101, 6'd0, 1'b0);
        chk_state("go_plus_x", 2'b01, 6'b000101, 6'd0, 1'b0, 1'b0);

        // x and y together from IDLE
        do_press(0, 0, 0, 1, 0, 0, 0, 0, 0);
        sw = 6'b100100;
        do_press(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_state("x_plus_y", 2'b10, 6'b100100, 6'b100100, 1'b0, 1'b0);

        // clr beats go
        sw_sel = 1;
        do_press(0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk_state("clr_plus_go", 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);

        // Reset mid-debounce discards the partial count
        sw = 6'b101010;
        @(negedge clk);
        btn_x = 1;
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (7) @(negedge clk);
        chk("rst_mid_early_x", {26'b0, x}, 32'd0);
        @(negedge clk);
        chk("rst_mid_load_x", {26'b0, x}, {26'b0, 6'b101010});
        chk("rst_mid_led", {30'b0, led_state}, {30'b0, 2'b01});
        btn_x = 0;
        repeat (12) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
